// File: rtl/rca_rgst_no_shift_if.sv
// -----------------------------------------------------------------------------
// rca_rgst_no_shift_if
// Bundles the control, operand and result signals of rca_rgst_no_shift.
// clk and rst_b are not part of the bundle; they stay plain ports on the block.
//
// Parameter:
//   w           datapath width in bits; must match the w of the attached block
//
// Signals:
//   clr         synchronous clear request
//   en          load enable (level sampled on each rising edge)
//   y  [w-1:0]  second adder operand (addend)
//   cin         adder carry-in
//   q  [w-1:0]  register contents (also the adder's first operand)
//   z  [w-1:0]  combinational sum q + y + cin, modulo 2^w
//   cout        combinational carry out of the MSB
//   overflow    combinational signed overflow
//   ovf_sticky  registered sticky overflow (0 unless the sticky build is used)
//
// Modports:
//   master      drives clr/en/y/cin and observes the results
//   slave       the adder/register block itself
// -----------------------------------------------------------------------------
interface rca_rgst_no_shift_if #(
   parameter int w = 4
);
   logic         clr;
   logic         en;
   logic [w-1:0] y;
   logic         cin;
   logic [w-1:0] q;
   logic [w-1:0] z;
   logic         cout;
   logic         overflow;
   logic         ovf_sticky;

   modport master (
      output clr, en, y, cin,
      input  q, z, cout, overflow, ovf_sticky
   );

   modport slave (
      input  clr, en, y, cin,
      output q, z, cout, overflow, ovf_sticky
   );
endinterface

// File: rtl/rca_rgst_no_shift.sv
// -----------------------------------------------------------------------------
// rca_rgst_no_shift
// Ripple-carry adder fused with a parallel-load, non-shifting register. The
// register output q is fed back as the adder's first operand, so with y = 1 and
// cin = 0 the block counts up; with an arbitrary y it accumulates.
//
// Parameter:
//   w      datapath width in bits (>= 1); must equal the width of the bus
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_b  synchronous active-high reset: q <= 0, ovf_sticky <= 0
//   bus    rca_rgst_no_shift_if.slave carrying clr, en, y, cin (inputs) and
//          q, z, cout, overflow, ovf_sticky (outputs)
//
// Register update priority on each rising edge: rst_b, then clr, then en
// (q <= z), otherwise hold. z, cout and overflow are purely combinational.
//
// Build option:
//   RCA_RGST_STICKY_OVF_EN  when defined, ovf_sticky is a flip-flop that sets
//                           on an enabled edge with overflow = 1 and clears on
//                           rst_b or clr. When undefined, ovf_sticky is tied
//                           to 0 and no flip-flop exists for it.
// -----------------------------------------------------------------------------
module rca_rgst_no_shift #(
   parameter int w = 4
) (
   input  logic                  clk,
   input  logic                  rst_b,
   rca_rgst_no_shift_if.slave    bus
);

   logic [w-1:0] q_reg;
   logic [w-1:0] q_next;
   logic [w-1:0] sum;
   logic [w:0]   carry;   // carry[i] is the carry into bit i; carry[w] is cout

   // ---------------------------------------------------------------------------
   // Ripple-carry adder: one explicit full adder per bit so the carry chain is
   // a true ripple from cin/q[0] to cout.
   // ---------------------------------------------------------------------------
   assign carry[0] = bus.cin;

   generate
      for (genvar gi = 0; gi < w; gi++) begin : g_fa
         logic p;   // propagate
         assign p             = q_reg[gi] ^ bus.y[gi];
         assign sum[gi]       = p ^ carry[gi];
         assign carry[gi + 1] = (q_reg[gi] & bus.y[gi]) | (carry[gi] & p);
      end
   endgenerate

   assign bus.z        = sum;
   assign bus.cout     = carry[w];
   // Signed overflow: carry into the MSB differs from carry out of it. For
   // w = 1 this reduces to cin ^ cout.
   assign bus.overflow = carry[w] ^ carry[w - 1];

   // ---------------------------------------------------------------------------
   // Register next-state: reset handled in the flop, clear beats load, load
   // beats hold.
   // ---------------------------------------------------------------------------
   always_comb begin
      q_next = q_reg;
      if (bus.clr) begin
         q_next = '0;
      end else if (bus.en) begin
         q_next = sum;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_b) begin
         q_reg <= '0;
      end else begin
         q_reg <= q_next;
      end
   end

   assign bus.q = q_reg;

   // ---------------------------------------------------------------------------
   // Optional sticky overflow flag.
   // ---------------------------------------------------------------------------
`ifdef RCA_RGST_STICKY_OVF_EN
   logic ovf_sticky_reg;
   logic ovf_sticky_next;

   always_comb begin
      ovf_sticky_next = ovf_sticky_reg;
      if (bus.clr) begin
         ovf_sticky_next = 1'b0;
      end else if (bus.en && bus.overflow) begin
         ovf_sticky_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_b) begin
         ovf_sticky_reg <= 1'b0;
      end else begin
         ovf_sticky_reg <= ovf_sticky_next;
      end
   end

   assign bus.ovf_sticky = ovf_sticky_reg;
`else
   assign bus.ovf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_rca_rgst_no_shift.sv
// -----------------------------------------------------------------------------
// tb_rca_rgst_no_shift
// Self-checking bench for rca_rgst_no_shift (w = 4). Each call to step()
// drives one cycle of inputs, checks the combinational outputs against an
// arithmetic model, pushes the expected register state into a scoreboard
// queue, and after the next rising edge pops and compares q / ovf_sticky.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rca_rgst_no_shift;

   localparam int W = 4;

   logic clk;
   logic rst_b;

   rca_rgst_no_shift_if #(.w(W)) bus ();

   rca_rgst_no_shift #(.w(W)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] q;
      logic         s;
   } exp_t;

   exp_t sb[$];

   int total = 0;
   int bad   = 0;

   // Model state
   int m_q     = 0;
   bit m_s     = 1'b0;
   bit m_known = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int to_signed(input int v);
      return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
   endfunction

   // One cycle: drive inputs, check combinational outputs, push expectation,
   // clock, pop and compare.
   task automatic step(input bit r, input bit c, input bit e,
                       input int yy, input bit ci);
      int   sum;
      int   ssum;
      bit   ovf;
      exp_t ex;
      exp_t got;
      rst_b   = r;
      bus.clr = c;
      bus.en  = e;
      bus.y   = yy[W-1:0];
      bus.cin = ci;
      #1;
      sum  = m_q + yy + int'(ci);
      ssum = to_signed(m_q) + to_signed(yy) + int'(ci);
      ovf  = (ssum > (1 << (W - 1)) - 1) || (ssum < -(1 << (W - 1)));
      if (m_known) begin
         check_val("z",        32'(bus.z),        32'(sum % (1 << W)));
         check_val("cout",     32'(bus.cout),     32'(sum >= (1 << W)));
         check_val("overflow", 32'(bus.overflow), 32'(ovf));
      end
      if (r) begin
         m_q = 0; m_s = 1'b0; m_known = 1'b1;
      end else if (c) begin
         m_q = 0; m_s = 1'b0;
      end else if (e) begin
         m_q = sum % (1 << W);
`ifdef RCA_RGST_STICKY_OVF_EN
         if (ovf) m_s = 1'b1;
`endif
      end
      ex.q = m_q[W-1:0];
      ex.s = m_s;
      sb.push_back(ex);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      if (m_known) begin
         check_val("q",          32'(bus.q),          32'(got.q));
         check_val("ovf_sticky", 32'(bus.ovf_sticky), 32'(got.s));
      end
      $display("step rst=%0d clr=%0d en=%0d y=%0d cin=%0d -> q=%0d sticky=%0d",
               r, c, e, yy, ci, bus.q, bus.ovf_sticky);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_b = 1'b0; bus.clr = 1'b0; bus.en = 1'b0; bus.y = '0; bus.cin = 1'b0;

      // Reset, then count to 5
      step(1, 0, 1, 1, 0);
      check_val("reset_q", 32'(bus.q), 32'd0);
      repeat (5) step(0, 0, 1, 1, 0);
      check_val("count5", 32'(bus.q), 32'd5);

      // Clear wins over enable, then count to 3
      step(0, 1, 1, 1, 0);
      check_val("clr_q", 32'(bus.q), 32'd0);
      repeat (3) step(0, 0, 1, 1, 0);
      check_val("count3", 32'(bus.q), 32'd3);

      // Up to 6, then hold for 3 edges; z keeps showing 7
      repeat (3) step(0, 0, 1, 1, 0);
      repeat (3) step(0, 0, 0, 1, 0);
      check_val("hold_q", 32'(bus.q), 32'd6);
      check_val("hold_z", 32'(bus.z), 32'd7);

      // Up to 14, then wrap through 15 to 0
      repeat (8) step(0, 0, 1, 1, 0);
      check_val("q14", 32'(bus.q), 32'd14);
      step(0, 0, 1, 1, 0);
      check_val("cout_at_15", 32'(bus.cout), 32'd1);
      step(0, 0, 1, 1, 0);
      check_val("wrap_q", 32'(bus.q), 32'd0);

      // Accumulate: q = 5, y = 3, cin = 1 -> z = 9 with signed overflow
      repeat (5) step(0, 0, 1, 1, 0);
      bus.y = 4'd3; bus.cin = 1'b1; bus.en = 1'b1;
      #1;
      check_val("acc_z",    32'(bus.z),        32'd9);
      check_val("acc_ovf",  32'(bus.overflow), 32'd1);
      check_val("acc_cout", 32'(bus.cout),     32'd0);
      step(0, 0, 1, 3, 1);
      check_val("acc_q", 32'(bus.q), 32'd9);
      repeat (3) step(0, 0, 0, 0, 0);   // sticky (if built) must hold
      step(0, 1, 0, 0, 0);               // clear drops it
      check_val("clr_sticky", 32'(bus.ovf_sticky), 32'd0);

      // Reset beats enable at q = 7
      repeat (7) step(0, 0, 1, 1, 0);
      check_val("q7", 32'(bus.q), 32'd7);
      step(1, 0, 1, 1, 0);
      check_val("rst_prio", 32'(bus.q), 32'd0);

      // Random accumulate traffic
      for (int i = 0; i < 60; i++) begin
         step(0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
              int'($urandom_range(0, (1 << W) - 1)), bit'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rca_rgst_no_shift.md
# rca_rgst_no_shift

Parameterised ripple-carry adder fused with a parallel-load, non-shifting register; the register output feeds back into the adder's first operand. With the addend tied to 1 and carry-in tied to 0, the block is the datapath core of the design's up-counters. With an arbitrary addend it serves as a simple accumulator for the ALU.

## Interface
- `w`, default 4: datapath width in bits, ≥ 1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_b`  in  1  reset, synchronous, active-high; `q` ← 0 and sticky flag ← 0 on the edge.
- `clr`  in  1  synchronous clear; `q` ← 0 on the edge.
- `en`  in  1  load enable; `q` ← adder sum `z` on the edge; when low, `q` holds.
- `y`  in  w  second adder operand (addend); the counter use ties it to 1.
- `cin`  in  1  adder carry-in.
- `q`  out  w  register contents; also the adder's first operand `x`.
- `z`  out  w  combinational sum `q + y + cin`, modulo 2^w.
- `cout`  out  1  combinational carry out of bit w-1.
- `overflow`  out  1  combinational signed overflow: carry into the MSB XOR carry out of the MSB.
- `ovf_sticky`  out  1  registered sticky overflow; see Configuration.

## Operation
- Adder:
  - True ripple chain of w full adders.
  - Bit i: `z[i] = q[i]^y[i]^c[i]`; `c[i+1] = q[i]&y[i] | c[i]&(q[i]^y[i])`; `c[0] = cin`; `cout = c[w]`.
- Register update priority, evaluated on each rising edge:
  - `rst_b` = 1 → `q` = 0.
  - Else `clr` = 1 → `q` = 0.
  - Else `en` = 1 → `q` = `z`.
  - Else `q` holds.
- Wrap-around:
  - Sum is modulo 2^w and no saturation is applied.
  - `q` = 2^w − 1 with `y` = 1, `cin` = 0 → next `q` = 0, and `cout` = 1 in the preceding cycle.
- `clr` together with `en` → clear wins; the sum is discarded.
- `rst_b` together with anything → reset wins.
- `en` low for any number of cycles → `q` is stable; `z`, `cout` and `overflow` still track `y` and `cin` combinationally.
- Signed overflow is determined per bit width:
  - w = 4, `q` = 0111, `y` = 0001 → `overflow` = 1.
  - w = 1 → `overflow` = `cin` XOR `cout`.

## Timing
- Load/update latency: 1 cycle. `q` reflects the `z` value sampled at the rising edge immediately after `en` is seen high.
- `z`, `cout`, `overflow`: combinational, with no register stage.
- Critical path: w carry stages from `cin`/`q[0]` to `z[w-1]`/`cout`.
- Reset is synchronous. The first edge with `rst_b` = 1 forces `q` = 0 and `ovf_sticky` = 0.
- Before the first reset edge, `q` is undefined.
- Deasserting `rst_b` mid-run resumes counting from 0 on the next enabled edge.
- No handshake: `en` is a level-sampled enable.

## Configuration
- Macro `RCA_RGST_STICKY_OVF_EN`.
- Defined:
  - `ovf_sticky` is a flip-flop.
  - Set to 1 on any edge where `en` = 1, no reset/clear is active, and `overflow` = 1.
  - Cleared by `rst_b` or `clr`; otherwise holds.
- Undefined: `ovf_sticky` is tied to 0 and no extra flip-flop is instantiated.
- `q`, `z`, `cout` and `overflow` are identical in both builds.

## Test plan
- Reset:
  - w = 4, `y` = 1, `cin` = 0, `en` = 1.
  - Hold `rst_b` = 1 for one edge, then release → `q` = 0.
  - After 5 edges → `q` = 5 (0101).
- Clear and re-count:
  - From `q` = 5, assert `clr` for one cycle with `en` = 1 → `q` = 0.
  - 3 more enabled edges → `q` = 3.
- Hold: `en` = 0 for 3 edges at `q` = 6 → `q` stays 0110; `z` = 0111.
- Wrap:
  - From `q` = 14, 2 enabled edges → `q` = 15, then 0.
  - `cout` = 1 while `q` = 15.
- Accumulate and overflow:
  - `y` = 3, `cin` = 1, `q` = 5 → `z` = 9, `overflow` = 1, `cout` = 0.
  - After an enabled edge → `q` = 9.
  - With the macro defined, `ovf_sticky` = 1 and stays 1 until `clr`.
- Priority: `rst_b` = 1, `clr` = 0, `en` = 1 at `q` = 7 → `q` = 0 on the next edge, not 8.
